// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the MAC job sequencer.
package mac_seq_pkg;
  localparam int OP_W  = 8;
  localparam int ACC_W = 17;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } mac_state_e;
endpackage

// File: rtl/mac_term_counter.sv
// Loadable down-counter tracking the remaining terms of a job; holds at zero.
module mac_term_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dec_i,
  output logic             last_o,
  output logic             zero_o
);
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = len_i;
    else if (dec_i && !zero_o)
      cnt_d = cnt_q - LEN_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == LEN_W'(1));
endmodule

// File: rtl/mac_job_sequencer.sv
// Drives a shared 8x8 multiply / 17-bit accumulate datapath through length-N jobs.
// Optional RUN stall timeout is enabled by defining MAC_TIMEOUT_EN.
module mac_job_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 4
`ifdef MAC_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [OP_W-1:0]  op_a_i,
  input  logic [OP_W-1:0]  op_b_i,
  output logic             mac_clr_o,
  output logic             mac_en_o,
  output logic [OP_W-1:0]  mac_a_o,
  output logic [OP_W-1:0]  mac_b_o,
  input  logic [ACC_W-1:0] mac_result_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ACC_W-1:0] res_data_o,
  output logic             res_ovf_o,
  output logic             res_abort_o
);
  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_CLR   = CLR;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_DONE  = DONE;

  logic [2:0]       state_q, state_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic             load, last, zero;
  logic             cmd_hs;

  assign cmd_ready_o = (state_q == S_IDLE);
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign op_ready_o  = (state_q == S_RUN) && !zero;
  assign mac_en_o    = op_valid_i && op_ready_o;
  assign mac_clr_o   = (state_q == S_CLR);
  assign mac_a_o     = op_a_i;
  assign mac_b_o     = op_b_i;
  assign res_valid_o = (state_q == S_DONE);
  assign res_data_o  = res_data_q;
  assign res_ovf_o   = ovf_q;
  assign load        = cmd_hs;

  mac_term_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load),
    .len_i   (cmd_len_i),
    .dec_i   (mac_en_o),
    .last_o  (last),
    .zero_o  (zero)
  );

`ifdef MAC_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               abort_q, abort_d;
  logic               stall_hit;

  // A mac_en cycle always restarts the count, so the abort sees a settled sum.
  assign stall_hit = (state_q == S_RUN) && !mac_en_o &&
                     (stall_q == STALL_W'(TIMEOUT - 1));

  always_comb begin
    stall_d = '0;
    if (state_q == S_RUN && !mac_en_o) stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

  assign res_abort_o = abort_q;
`else
  assign res_abort_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ovf_d      = ovf_q;
    res_data_d = res_data_q;
`ifdef MAC_TIMEOUT_EN
    abort_d    = abort_q;
`endif
    case (state_q)
      S_IDLE: if (cmd_hs) begin
        state_d = S_CLR;
        ovf_d   = 1'b0;
`ifdef MAC_TIMEOUT_EN
        abort_d = 1'b0;
`endif
      end
      S_CLR: state_d = zero ? S_DRAIN : S_RUN;
      S_RUN: begin
        ovf_d = ovf_q | mac_result_i[ACC_W-1];
        if (mac_en_o && last) state_d = S_DRAIN;
`ifdef MAC_TIMEOUT_EN
        else if (stall_hit) begin
          state_d    = S_DONE;
          abort_d    = 1'b1;
          res_data_d = mac_result_i;
        end
`endif
      end
      S_DRAIN: begin
        // Last mac_en landed last cycle, so the datapath sum is final here.
        ovf_d      = ovf_q | mac_result_i[ACC_W-1];
        res_data_d = mac_result_i;
        state_d    = S_DONE;
      end
      S_DONE: if (res_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      ovf_q      <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      res_data_q <= res_data_d;
    end
  end
endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural multiply-accumulate datapath.
module tb_mac_job_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_len;
  logic        op_valid, op_ready;
  logic [7:0]  op_a, op_b;
  logic        mac_clr, mac_en;
  logic [7:0]  mac_a, mac_b;
  logic [16:0] mac_result;
  logic        res_valid, res_ready;
  logic [16:0] res_data;
  logic        res_ovf, res_abort;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int c0, e0, k0;

  logic [16:0] acc = '0;

  always #5 clk = ~clk;

  // Datapath stand-in: result updates the cycle after clr/en.
  always @(posedge clk) begin
    if (mac_clr)     acc <= '0;
    else if (mac_en) acc <= acc + 17'(mac_a) * 17'(mac_b);
    if (mac_en)  en_cnt  <= en_cnt + 1;
    if (mac_clr) clr_cnt <= clr_cnt + 1;
  end
  assign mac_result = acc;

  mac_job_sequencer #(.LEN_W(4)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_len_i    (cmd_len),
    .op_valid_i   (op_valid),
    .op_ready_o   (op_ready),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .mac_clr_o    (mac_clr),
    .mac_en_o     (mac_en),
    .mac_a_o      (mac_a),
    .mac_b_o      (mac_b),
    .mac_result_i (mac_result),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_ovf_o    (res_ovf),
    .res_abort_o  (res_abort)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present cmd for one accepted cycle; returns in the CLR cycle.
  task automatic start_cmd(input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_len   = len;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("mac_clr_pulse", 32'(mac_clr), 32'd1);
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input int gap);
    int w;
    op_valid = 1'b0;
    for (int i = 0; i < gap; i++) step();
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    w = 0;
    while (!op_ready && w < 20) begin
      chk("no_en_without_ready", 32'(mac_en), 32'd0);
      step();
      w++;
    end
    if (w >= 20) chk("op_ready_timeout", 32'd0, 32'd1);
    step();
    op_valid = 1'b0;
  endtask

  task automatic wait_res();
    int w;
    w = 0;
    while (!res_valid && w < 200) begin
      step();
      w++;
    end
    if (w >= 200) chk("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic res_hs();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_valid_cleared", 32'(res_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_mac_clr", 32'(mac_clr), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_ovf", 32'(res_ovf), 32'd0);
    chk("rst_res_abort", 32'(res_abort), 32'd0);

    // 1: len=3 back-to-back, 6+20+100
    e0 = en_cnt; k0 = clr_cnt;
    start_cmd(4'd3);
    c0 = cyc;
    send_op(8'd2, 8'd3, 0);
    send_op(8'd4, 8'd5, 0);
    send_op(8'd10, 8'd10, 0);
    wait_res();
    chk("t1_latency", 32'(cyc - c0), 32'd5);
    chk("t1_res_data", 32'(res_data), 32'd126);
    chk("t1_res_ovf", 32'(res_ovf), 32'd0);
    chk("t1_res_abort", 32'(res_abort), 32'd0);
    chk("t1_en_pulses", 32'(en_cnt - e0), 32'd3);
    chk("t1_clr_pulses", 32'(clr_cnt - k0), 32'd1);
    res_hs();

    // 2: 255*255*2 sets bit 16
    start_cmd(4'd2);
    send_op(8'd255, 8'd255, 0);
    send_op(8'd255, 8'd255, 0);
    wait_res();
    chk("t2_res_data", 32'(res_data), 32'h1FC02);
    chk("t2_res_ovf", 32'(res_ovf), 32'd1);
    res_hs();

    // 3: len=0, operands offered but never consumed
    e0 = en_cnt;
    op_valid = 1'b1; op_a = 8'd9; op_b = 8'd9;
    start_cmd(4'd0);
    chk("t3_ovf_cleared", 32'(res_ovf), 32'd0);
    c0 = cyc;
    while (!res_valid && cyc - c0 < 10) begin
      chk("t3_no_op_ready", 32'(op_ready), 32'd0);
      step();
    end
    op_valid = 1'b0;
    chk("t3_latency", 32'(cyc - c0), 32'd2);
    chk("t3_res_data", 32'(res_data), 32'd0);
    chk("t3_no_en", 32'(en_cnt - e0), 32'd0);
    res_hs();

    // 4: bubbles, then consumer stalls 5 cycles with a pending cmd
    start_cmd(4'd2);
    send_op(8'd1, 8'd2, 2);
    send_op(8'd3, 8'd4, 3);
    wait_res();
    cmd_valid = 1'b1; cmd_len = 4'd5;
    for (int i = 0; i < 5; i++) begin
      chk("t4_res_valid_hold", 32'(res_valid), 32'd1);
      chk("t4_res_data_hold", 32'(res_data), 32'd14);
      chk("t4_cmd_blocked", 32'(cmd_ready), 32'd0);
      step();
    end
    cmd_valid = 1'b0;
    res_hs();

    // 5: reset mid-job after one of three terms
    start_cmd(4'd3);
    send_op(8'd5, 8'd5, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5_op_ready", 32'(op_ready), 32'd0);
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    chk("t5_res_data", 32'(res_data), 32'd0);
    start_cmd(4'd1);
    send_op(8'd7, 8'd7, 0);
    wait_res();
    chk("t5_res_data_next", 32'(res_data), 32'd49);
    res_hs();

`ifdef MAC_TIMEOUT_EN
    // 6: one term then stall until the timeout aborts with the partial sum
    start_cmd(4'd3);
    send_op(8'd3, 8'd3, 0);
    wait_res();
    chk("t6_res_abort", 32'(res_abort), 32'd1);
    chk("t6_res_data", 32'(res_data), 32'd9);
    res_hs();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
